mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the MIPS datapath: a Moore state machine plus ALU decoder that sequences each instruction over 3–5 cycles. It drives the datapath enables and the 3-bit `alucontrol` consumed by the ALU, and takes back the ALU `zero` and `sign` flags to resolve `beq`/`ble`. It sits directly upstream of the ALU and owns all PC, memory and register-file write enables.

## Interface
- `OP_BLE`, 6'b000110, opcode of `ble rs, rt, label`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge forces state FETCH.
- `op`  in  6  instruction[31:26], taken from the instruction register.
- `funct`  in  6  instruction[5:0].
- `zero`  in  1  ALU result == 0.
- `sign`  in  1  ALU result[31].
- `pcen`  out  1  PC register enable.
- `memwrite`  out  1  data memory write.
- `irwrite`  out  1  instruction register load.
- `regwrite`  out  1  register file write.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memtoreg`  out  1  writeback select: 0 = ALUOut, 1 = Data.
- `regdst`  out  1  destination select: 0 = rt, 1 = rd.
- `alusrca`  out  2  ALU A select: 00 = PC, 01 = A reg, 10 = zero-extended shamt.
- `alusrcb`  out  2  ALU B select: 00 = B reg, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll.
- `state`  out  4  current state encoding, for debug and the bench.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BLEEX 12. Encodings 13–15 go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE on `op`: 100011/101011→MEMADR, 000000→RTYPEEX, 000100→BEQEX, 001000→ADDIEX, 000010→JEX, OP_BLE→BLEEX, any other→FETCH (NOP).
  - MEMADR→MEMRD if `op`=100011, else MEMWR.
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX, BLEEX→FETCH.
- Outputs are Moore. Every output not listed for a state is 0.
  - FETCH: `irwrite`=1, `alusrcb`=01, `pcsrc`=00, add, PC write.
  - DECODE: `alusrcb`=11, add (computes the branch target).
  - MEMADR: `alusrca`=01, `alusrcb`=10, add.
  - MEMRD: `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=01 (10 when `funct`=000000, sll), `alusrcb`=00, funct-decoded.
  - RTYPEWB: `regwrite`=1, `regdst`=1.
  - ADDIEX: `alusrca`=01, `alusrcb`=10, add.
  - ADDIWB: `regwrite`=1.
  - BEQEX and BLEEX: `alusrca`=01, `alusrcb`=00, sub, `pcsrc`=01.
  - JEX: `pcsrc`=10, PC write.
- Funct decode applies in RTYPEEX only: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll. Any other funct gives 010 (add).
- `pcen` = pcwrite | (BEQEX & `zero`) | (BLEEX & (`zero` | `sign`)), where pcwrite is 1 in FETCH and JEX only.
- `ble` is taken when rs − rt ≤ 0 per the ALU `sign` flag, i.e. the 32-bit wrapped difference. Overflow is not corrected.

## Timing
- Next-state logic is registered. All outputs are combinational from `state` (and `op`/`funct`/flags where noted). `zero` and `sign` are sampled in the same cycle as the BEQEX/BLEEX compare.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, ble 3, j 3, unknown opcode 2.
- While `reset`=0: `pcen`, `irwrite`, `memwrite` and `regwrite` are forced to 0. Other outputs follow FETCH values: `alusrcb`=01, `alucontrol`=010, all others 0.
- After the first edge with `reset`=0, `state`=0.
- Reset asserted mid-instruction aborts it at the next edge. No write enable is asserted in the cycle in which `reset`=0.
- The first FETCH begins on the first edge with `reset`=1.

## Test plan
- Reset: hold `reset`=0 for 2 edges in state MEMWB → `state`=0, `regwrite`=0, `pcen`=0. Release → FETCH, DECODE on consecutive cycles.
- lw (`op`=100011): state sequence 0,1,2,3,4,0. `iord`=1 in states 3; `regwrite`=1 and `memtoreg`=1 only in state 4. sw (`op`=101011): sequence 0,1,2,5,0 with `memwrite`=1 only in state 5.
- R-type funct sweep in RTYPEEX: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, 000000→011 with `alusrca`=10, 111111→010. RTYPEWB: `regdst`=1, `regwrite`=1.
- beq in BEQEX: `zero`=1 → `pcen`=1, `pcsrc`=01; `zero`=0 → `pcen`=0. Both cases return to FETCH next.
- ble in BLEEX: (`zero`,`sign`) = (0,0) → `pcen`=0; (1,0) → 1; (0,1) → 1. `alucontrol`=110.
- j → `pcsrc`=10 and `pcen`=1 in state 11. Unknown `op`=111111 → DECODE→FETCH with no write enable. Force `state`=13 → FETCH next edge.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore sequencer plus the ALU decoder for R-type funct codes.
// Branch resolution for beq/ble uses the ALU zero/sign flags sampled in the compare state.
module mc_controller #(
  parameter logic [5:0] OP_BLE = 6'b000110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       sign,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BLEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // Kept as a plain vector so unused encodings 13-15 are representable and recover to FETCH.
  logic [3:0] state_r;
  logic [3:0] state_next;
  logic       pcwrite;

  function automatic logic [2:0] funct_ctl(input logic [5:0] f);
    case (f)
      6'b100000: funct_ctl = 3'b010;
      6'b100010: funct_ctl = 3'b110;
      6'b100100: funct_ctl = 3'b000;
      6'b100101: funct_ctl = 3'b001;
      6'b101010: funct_ctl = 3'b111;
      6'b000000: funct_ctl = 3'b011;
      default:   funct_ctl = 3'b010;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state_r <= FETCH;
    else        state_r <= state_next;
  end

  assign state = state_r;

  always_comb begin
    state_next = FETCH;
    case (state_r)
      FETCH:  state_next = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW) state_next = MEMADR;
        else if (op == OP_RTYPE)        state_next = RTYPEEX;
        else if (op == OP_BEQ)          state_next = BEQEX;
        else if (op == OP_ADDI)         state_next = ADDIEX;
        else if (op == OP_J)            state_next = JEX;
        else if (op == OP_BLE)          state_next = BLEEX;
        else                            state_next = FETCH;
      end
      MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = MEMWB;
      RTYPEEX: state_next = RTYPEWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    pcwrite    = 1'b0;
    pcen       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    case (state_r)
      FETCH: begin
        irwrite    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        pcwrite    = 1'b1;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        // sll takes its A operand from the shamt field rather than rs
        alusrca    = (funct == 6'b000000) ? 2'b10 : 2'b01;
        alucontrol = funct_ctl(funct);
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      BEQEX, BLEEX: begin
        alusrca    = 2'b01;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase

    pcen = pcwrite
         | ((state_r == BEQEX) & zero)
         | ((state_r == BLEEX) & (zero | sign));

    // Reset presents FETCH steering with every write enable held off.
    if (!reset) begin
      pcen       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 2'b00;
      alusrcb    = 2'b01;
      pcsrc      = 2'b00;
      alucontrol = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: table of per-cycle vectors covering each instruction class,
// plus hand sequences for reset abort and illegal-state recovery.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       sign;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst;
  logic [1:0] alusrca, alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [15:0] outs;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .sign(sign),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  assign outs = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                 alusrca, alusrcb, pcsrc, alucontrol};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst, alusrca, alusrcb, pcsrc, alucontrol}
  localparam logic [15:0] O_RST = 16'b0000000_00_01_00_010;
  localparam logic [15:0] O_FET = 16'b1010000_00_01_00_010;
  localparam logic [15:0] O_DEC = 16'b0000000_00_11_00_010;
  localparam logic [15:0] O_MAD = 16'b0000000_01_10_00_010;
  localparam logic [15:0] O_MRD = 16'b0000100_00_00_00_000;
  localparam logic [15:0] O_MWB = 16'b0001010_00_00_00_000;
  localparam logic [15:0] O_MWR = 16'b0100100_00_00_00_000;
  localparam logic [15:0] O_RWB = 16'b0001001_00_00_00_000;
  localparam logic [15:0] O_AWB = 16'b0001000_00_00_00_000;
  localparam logic [15:0] O_JEX = 16'b1000000_00_00_10_000;
  localparam logic [15:0] O_BRN = 16'b0000000_01_00_01_110;
  localparam logic [15:0] O_BRT = 16'b1000000_01_00_01_110;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         ADDI = 6'b001000, JMP = 6'b000010, BLE = 6'b000110, BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        sign;
    logic [3:0]  st;
    logic [15:0] out;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(input logic r, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input logic s, input logic [3:0] st,
                              input logic [15:0] ex);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.sign = s; v.st = st; v.out = ex;
    vecs.push_back(v);
  endfunction

  function automatic logic [15:0] rex(input logic [1:0] a, input logic [2:0] ctl);
    rex = {7'b0000000, a, 2'b00, 2'b00, ctl};
  endfunction

  task automatic rtype(input logic [5:0] f, input logic [1:0] a, input logic [2:0] ctl);
    add(1, RT, f, 0, 0, 4'd0, O_FET);
    add(1, RT, f, 0, 0, 4'd1, O_DEC);
    add(1, RT, f, 0, 0, 4'd6, rex(a, ctl));
    add(1, RT, f, 0, 0, 4'd7, O_RWB);
  endtask

  task automatic branch(input logic [5:0] o, input logic z, input logic s,
                        input logic [3:0] st, input logic [15:0] ex);
    add(1, o, 6'd0, z, s, 4'd0, O_FET);
    add(1, o, 6'd0, z, s, 4'd1, O_DEC);
    add(1, o, 6'd0, z, s, st, ex);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0; op = LW; funct = 6'd0; zero = 1'b0; sign = 1'b0;

    // reset held low: forced FETCH outputs, no writes
    add(0, LW, 6'd0, 0, 0, 4'd0, O_RST);
    // lw
    add(1, LW, 6'd0, 0, 0, 4'd0, O_FET);
    add(1, LW, 6'd0, 0, 0, 4'd1, O_DEC);
    add(1, LW, 6'd0, 1, 1, 4'd2, O_MAD);
    add(1, LW, 6'd0, 0, 0, 4'd3, O_MRD);
    add(1, LW, 6'd0, 0, 0, 4'd4, O_MWB);
    // sw
    add(1, SW, 6'd0, 0, 0, 4'd0, O_FET);
    add(1, SW, 6'd0, 0, 0, 4'd1, O_DEC);
    add(1, SW, 6'd0, 0, 0, 4'd2, O_MAD);
    add(1, SW, 6'd0, 0, 0, 4'd5, O_MWR);
    // R-type funct sweep
    rtype(6'b100000, 2'b01, 3'b010);
    rtype(6'b100010, 2'b01, 3'b110);
    rtype(6'b100100, 2'b01, 3'b000);
    rtype(6'b100101, 2'b01, 3'b001);
    rtype(6'b101010, 2'b01, 3'b111);
    rtype(6'b000000, 2'b10, 3'b011);
    rtype(6'b111111, 2'b01, 3'b010);
    // beq taken / not taken (sign alone must not take beq)
    branch(BEQ, 1, 0, 4'd8, O_BRT);
    branch(BEQ, 0, 0, 4'd8, O_BRN);
    branch(BEQ, 0, 1, 4'd8, O_BRN);
    // ble on (zero,sign)
    branch(BLE, 0, 0, 4'd12, O_BRN);
    branch(BLE, 1, 0, 4'd12, O_BRT);
    branch(BLE, 0, 1, 4'd12, O_BRT);
    // j
    branch(JMP, 0, 0, 4'd11, O_JEX);
    // addi
    add(1, ADDI, 6'd0, 0, 0, 4'd0, O_FET);
    add(1, ADDI, 6'd0, 0, 0, 4'd1, O_DEC);
    add(1, ADDI, 6'd0, 0, 0, 4'd9, O_MAD);
    add(1, ADDI, 6'd0, 0, 0, 4'd10, O_AWB);
    // unknown opcode: DECODE straight back to FETCH
    add(1, BAD, 6'd0, 0, 0, 4'd0, O_FET);
    add(1, BAD, 6'd0, 0, 0, 4'd1, O_DEC);
    add(1, BAD, 6'd0, 0, 0, 4'd0, O_FET);
    add(1, BAD, 6'd0, 0, 0, 4'd1, O_DEC);
    // lw aborted by a two-edge reset while in MEMWB
    add(1, LW, 6'd0, 0, 0, 4'd0, O_FET);
    add(1, LW, 6'd0, 0, 0, 4'd1, O_DEC);
    add(1, LW, 6'd0, 0, 0, 4'd2, O_MAD);
    add(1, LW, 6'd0, 0, 0, 4'd3, O_MRD);
    add(0, LW, 6'd0, 0, 0, 4'd4, O_RST);
    add(0, LW, 6'd0, 0, 0, 4'd0, O_RST);
    add(1, LW, 6'd0, 0, 0, 4'd0, O_FET);
    add(1, LW, 6'd0, 0, 0, 4'd1, O_DEC);

    // initial reset edge so the state register is defined
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
      zero = vecs[i].zero; sign = vecs[i].sign;
      #1;
      check16($sformatf("state[%0d]", i), {12'd0, state}, {12'd0, vecs[i].st});
      check16($sformatf("outs[%0d]", i), outs, vecs[i].out);
    end

    // illegal encoding 13: no outputs, next state FETCH
    @(negedge clk);
    reset = 1'b1; op = LW; zero = 1'b1; sign = 1'b1;
    force dut.state_r = 4'd13;
    #1;
    check16("state13", {12'd0, state}, 16'd13);
    check16("outs13", outs, 16'd0);
    check16("next13", {12'd0, dut.state_next}, 16'd0);
    release dut.state_r;

    // resynchronise with reset, then confirm a clean FETCH/DECODE
    @(negedge clk);
    reset = 1'b0; zero = 1'b0; sign = 1'b0;
    @(negedge clk);
    #1;
    check16("resync_state", {12'd0, state}, 16'd0);
    check16("resync_outs", outs, O_RST);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check16("post_state", {12'd0, state}, 16'd1);
    check16("post_outs", outs, O_DEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
